// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai31_bist.sv
// Self-test sequencer for one oai31 cell: drives all 16 input vectors, checks ZN, and reports pass/fail, fail count and first failing vector.
// Latency: each vector is held SETTLE_CYCLES+1 cycles; DONE rises one cycle after the last check, once FAIL_CNT is final.
// Backpressure: none. START is a one-cycle pulse and is ignored while BUSY=1. Optional arc coverage: GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN.
module gf180mcu_fd_sc_mcu7t5v0__oai31_bist #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FAIL_CNT_W    = 5
) (
`ifdef USE_POWER_PINS
  inout  wire                   VDD,
  inout  wire                   VSS,
`endif
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ZN,
  output logic                  A1,
  output logic                  A2,
  output logic                  A3,
  output logic                  B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
  output logic [7:0]            ARC_MASK,
`endif
  output logic [FAIL_CNT_W-1:0] FAIL_CNT,
  output logic [3:0]            FIRST_FAIL
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [FAIL_CNT_W-1:0] FAIL_MAX    = '1;
  localparam logic [FAIL_CNT_W-1:0] FAIL_ONE    = FAIL_CNT_W'(1);

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [3:0]              settle_q, settle_d;
  logic [3:0]              vec_q, vec_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [3:0]              first_fail_q, first_fail_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
  logic [7:0]              arc_q, arc_d;
  logic                    zn_prev_q, zn_prev_d;
`endif

  logic exp_zn;
  logic mismatch;

  // Expected cell response for the vector currently on the pins; case compare so X/Z on ZN fails.
  always_comb begin
    exp_zn   = ~((vec_q[3] | vec_q[2] | vec_q[1]) & vec_q[0]);
    mismatch = (ZN !== exp_zn);
  end

  // Next-state logic for the sequencer and all registered outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
    arc_d        = arc_q;
    zn_prev_d    = zn_prev_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (busy_q) begin
          // Final cycle after the last check: publish verdict from the settled count.
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (fail_cnt_q == '0);
        end else if (START) begin
          state_d      = S_DRIVE;
          idx_d        = 4'd0;
          settle_d     = 4'd0;
          vec_d        = 4'd0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          fail_cnt_d   = '0;
          first_fail_d = 4'd0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
          arc_d        = 8'd0;
`endif
        end
      end
      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          if (fail_cnt_q == '0) first_fail_d = idx_q;
          if (fail_cnt_q != FAIL_MAX) fail_cnt_d = fail_cnt_q + FAIL_ONE;
        end
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
        // Even vector: remember ZN; odd vector: only B flipped, so a ZN change marks the arc.
        if (!idx_q[0]) zn_prev_d = ZN;
        else if (ZN !== zn_prev_q) arc_d[idx_q[3:1]] = 1'b1;
`endif
        if (idx_q == 4'd15) begin
          state_d = S_DONE;
          vec_d   = 4'd0;
        end else begin
          idx_d   = idx_q + 4'd1;
          vec_d   = idx_q + 4'd1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      settle_q     <= 4'd0;
      vec_q        <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= 4'd0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
      arc_q        <= 8'd0;
      zn_prev_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
      arc_q        <= arc_d;
      zn_prev_q    <= zn_prev_d;
`endif
    end
  end

  assign A1         = vec_q[3];
  assign A2         = vec_q[2];
  assign A3         = vec_q[1];
  assign B          = vec_q[0];
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign FAIL_CNT   = fail_cnt_q;
  assign FIRST_FAIL = first_fail_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
  assign ARC_MASK   = arc_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai31_bist.sv
// Bench for the oai31 self-test sequencer: behavioural cell models feed ZN, end-of-run results checked via scoreboard queues.
// Two instances share clock/reset/start: u0 (default widths, selectable cell fault) and u1 (2-bit counter, ZN stuck at 0).
// Each run checks vector timing and the exact DONE edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai31_bist;

  localparam int S = 2;

  typedef struct {
    int         fail_cnt;
    int         first_fail;
    logic       pass;
    logic [7:0] arc;
  } res_t;

  logic clk, rst, start;
  logic zn0, zn1;
  int   zn_mode;
  int   n_chk, n_fail;
  res_t sb0[$];
  res_t sb1[$];

  logic a1_0, a2_0, a3_0, b_0, busy0, done0, pass0;
  logic [4:0] fcnt0;
  logic [3:0] ff0;
  logic a1_1, a2_1, a3_1, b_1, busy1, done1, pass1;
  logic [1:0] fcnt1;
  logic [3:0] ff1;
  logic [7:0] arc0, arc1;

`ifdef USE_POWER_PINS
  wire vdd = 1'b1;
  wire vss = 1'b0;
`endif

  gf180mcu_fd_sc_mcu7t5v0__oai31_bist #(.SETTLE_CYCLES(S), .FAIL_CNT_W(5)) u0 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .START(start), .ZN(zn0),
    .A1(a1_0), .A2(a2_0), .A3(a3_0), .B(b_0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0),
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
    .ARC_MASK(arc0),
`endif
    .FAIL_CNT(fcnt0), .FIRST_FAIL(ff0)
  );

  gf180mcu_fd_sc_mcu7t5v0__oai31_bist #(.SETTLE_CYCLES(S), .FAIL_CNT_W(2)) u1 (
`ifdef USE_POWER_PINS
    .VDD(vdd), .VSS(vss),
`endif
    .CLK(clk), .RST(rst), .START(start), .ZN(zn1),
    .A1(a1_1), .A2(a2_1), .A3(a3_1), .B(b_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1),
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
    .ARC_MASK(arc1),
`endif
    .FAIL_CNT(fcnt1), .FIRST_FAIL(ff1)
  );

`ifndef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
  assign arc0 = 8'd0;
  assign arc1 = 8'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell behaviour: 0 ideal, 1 stuck-at-1, 2 stuck-at-0, 3 ideal except X on vector 5.
  function automatic logic zn_of(input int mode, input logic [3:0] v);
    logic ideal;
    ideal = ~((v[3] | v[2] | v[1]) & v[0]);
    case (mode)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return (v == 4'd5) ? 1'bx : ideal;
      default: return ideal;
    endcase
  endfunction

  always_comb zn0 = zn_of(zn_mode, {a1_0, a2_0, a3_0, b_0});
  assign zn1 = 1'b0;

  // Reference result of a complete 16-vector run for a given cell behaviour and counter width.
  function automatic res_t model(input int mode, input int w);
    res_t r;
    logic z, zp, e;
    int   mx;
    mx = (1 << w) - 1;
    r.fail_cnt = 0; r.first_fail = 0; r.arc = 8'd0; zp = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      z = zn_of(mode, v);
      e = ~((v[3] | v[2] | v[1]) & v[0]);
      if (z !== e) begin
        if (r.fail_cnt == 0) r.first_fail = i;
        if (r.fail_cnt < mx) r.fail_cnt++;
      end
      if (i % 2 == 1) begin
        if (z !== zp) r.arc[i / 2] = 1'b1;
      end else begin
        zp = z;
      end
    end
    r.pass = (r.fail_cnt == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_vec0",  {28'd0, a1_0, a2_0, a3_0, b_0}, 32'd0);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_pass0", pass0, 0);
    chk("rst_fcnt0", fcnt0, 0);
    chk("rst_ff0",   ff0, 0);
    chk("rst_vec1",  {28'd0, a1_1, a2_1, a3_1, b_1}, 32'd0);
    chk("rst_done1", done1, 0);
    chk("rst_fcnt1", fcnt1, 0);
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
    chk("rst_arc0", arc0, 0);
`endif
  endtask

  // Full run: START at edge 0, vector n/3 after edge n, DONE exactly after edge 16*(S+1)+1.
  task automatic run_full(input int mode);
    res_t r0, r1;
    int   done_at;
    zn_mode = mode;
    sb0.push_back(model(mode, 5));
    sb1.push_back(model(2, 2));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy0, 1);
    chk("start_done", done0, 0);
    chk("start_pass", pass0, 0);
    chk("start_vec",  {28'd0, a1_0, a2_0, a3_0, b_0}, 32'd0);
    done_at = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n < 16 * (S + 1))
        chk("vec", {28'd0, a1_0, a2_0, a3_0, b_0}, 32'(n / (S + 1)));
      if (done0 === 1'b1) begin
        done_at = n;
        break;
      end
    end
    chk("done_edge", 32'(done_at), 32'(16 * (S + 1) + 1));
    chk("end_busy", busy0, 0);
    chk("end_vec", {28'd0, a1_0, a2_0, a3_0, b_0}, 32'd0);
    if (sb0.size() != 0 && sb1.size() != 0) begin
      r0 = sb0.pop_front();
      r1 = sb1.pop_front();
      chk("fail_cnt", fcnt0, 32'(r0.fail_cnt));
      chk("first_fail", ff0, 32'(r0.first_fail));
      chk("pass", pass0, r0.pass);
`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN
      chk("arc_mask", arc0, r0.arc);
`endif
      chk("w2_done", done1, 1);
      chk("w2_fail_cnt", fcnt1, 32'(r1.fail_cnt));
      chk("w2_first_fail", ff1, 32'(r1.first_fail));
      chk("w2_pass", pass1, r1.pass);
    end else begin
      chk("sb_nonempty", 0, 1);
    end
  endtask

  // Second START mid-run must be ignored; a one-cycle RST at vector 9 aborts to reset values.
  task automatic run_abort();
    zn_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 28; n++) begin
      @(negedge clk);
      if (n == 18) begin
        chk("abort_vec6", {28'd0, a1_0, a2_0, a3_0, b_0}, 32'd6);
        start = 1'b1;
      end
      if (n == 19) begin
        start = 1'b0;
        chk("ign_busy", busy0, 1);
        chk("ign_vec6", {28'd0, a1_0, a2_0, a3_0, b_0}, 32'd6);
      end
      if (n == 27) begin
        chk("ign_vec9", {28'd0, a1_0, a2_0, a3_0, b_0}, 32'd9);
        rst = 1'b1;
      end
      if (n == 28) begin
        rst = 1'b0;
        chk_reset_vals();
      end
    end
    repeat (3) @(negedge clk);
    chk("idle_busy", busy0, 0);
    chk("idle_vec", {28'd0, a1_0, a2_0, a3_0, b_0}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; zn_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_nostart", busy0, 0);
    run_full(0);
    run_full(1);
    run_full(2);
    run_full(3);
    run_full(0);
    run_abort();
    run_full(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__oai31_bist.md
# gf180mcu_fd_sc_mcu7t5v0__oai31_bist

Self-test sequencer for the oai31 cell (ZN = !((A1|A2|A3)&B)). It drives A1/A2/A3/B of one cell instance through all 16 input vectors and samples the returned ZN. It compares each sample against the expected value and reports pass/fail, the failure count and the first failing vector. It sits directly upstream of the cell under test (feeding its inputs) and also consumes its ZN.

## Interface
- Clocking and reset are fixed: one clock; reset is synchronous and active-high.
- Parameters:
  - SETTLE_CYCLES, default 2: cycles each vector is held before the sample cycle. Legal range 1..15.
  - FAIL_CNT_W, default 5: width of the failure counter.
- Ports:
  - CLK  input  1  clock; all state changes on the rising edge.
  - RST  input  1  synchronous reset, active-high.
  - START  input  1  start request; a one-cycle pulse.
  - ZN  input  1  output of the oai31 cell under test.
  - A1, A2, A3, B  output  1 each  drive the cell-under-test inputs.
  - BUSY  output  1  sequence running.
  - DONE  output  1  sequence complete. Level signal, held until the next accepted START or RST.
  - PASS  output  1  DONE with zero failures.
  - FAIL_CNT  output  FAIL_CNT_W  number of mismatching vectors, saturating.
  - FIRST_FAIL  output  4  index of the first mismatching vector.
  - ARC_MASK  output  8  B→ZN arc coverage. Present only with the macro (see Configuration).
- Under USE_POWER_PINS the module adds inout VDD and VSS.

## Operation
- Vector index i (4-bit) maps to the outputs as A1=i[3], A2=i[2], A3=i[1], B=i[0]. Order is i = 0..15.
- Expected value: EXP = !((A1|A2|A3)&B), computed from the currently driven vector.
- FSM states:
  - IDLE:
    - A1..B driven 0.
    - START=1 → clear FAIL_CNT, FIRST_FAIL, ARC_MASK, DONE and PASS; set i=0; go to DRIVE.
  - DRIVE:
    - Outputs = vector i; settle counter runs.
    - After SETTLE_CYCLES cycles → CHECK.
  - CHECK:
    - Outputs still = vector i. ZN is sampled at the edge that ends this cycle.
    - Mismatch uses a case-inequality compare (ZN !== EXP), so X/Z on ZN counts as a failure.
    - On mismatch: FAIL_CNT increments, saturating at 2^FAIL_CNT_W−1.
    - If FAIL_CNT was 0, FIRST_FAIL ← i.
    - If i=15 → DONE state; else i+1 and go to DRIVE.
  - DONE:
    - A1..B driven 0; DONE=1.
    - PASS=1 iff FAIL_CNT==0. PASS is registered together with DONE.
    - START=1 → restart exactly as from IDLE.
- BUSY=1 in DRIVE and CHECK only.
- START is ignored while BUSY=1.
- FIRST_FAIL is meaningful only when FAIL_CNT≠0; otherwise it holds 0.

## Timing
- Reset values (at the first edge with RST=1): A1=A2=A3=B=0, BUSY=0, DONE=0, PASS=0, FAIL_CNT=0, FIRST_FAIL=0, ARC_MASK=0; state IDLE.
- RST has priority over START and over every state, including mid-sequence.
- Cycle timing:
  - START sampled at edge 0 → BUSY=1 and vector 0 driven after edge 0.
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - DONE rises after edge 16·(SETTLE_CYCLES+1)+1. With the default of 2, that is edge 49.
- BUSY falls in the same cycle that DONE rises.
- Outputs change only on CLK edges and are glitch-free registered outputs.
- ZN must settle within SETTLE_CYCLES cycles of an input change.

## Configuration
- Macro: GF180MCU_FD_SC_MCU7T5V0__OAI31_BIST_ARC_COVER_EN.
- Defined:
  - ARC_MASK port and register exist.
  - At the CHECK of an odd i, bit k=i[3:1] is set if ZN sampled now differs from ZN sampled at the CHECK of i−1. Only B changed between those two vectors, so this records B→ZN arc sensitization for {A1,A2,A3}=k.
  - ARC_MASK is cleared on an accepted START.
  - Correct cell result: 8'hFE. Bit 0 is the unsensitized arc and stays 0.
- Undefined: no ARC_MASK port, no ZN history register; all other behaviour is identical.

## Test plan
- Ideal oai31 model, SETTLE_CYCLES=2, START pulse → DONE and PASS rise after edge 49, FAIL_CNT=0, FIRST_FAIL=0, ARC_MASK=8'hFE (macro on).
- ZN stuck at 1 → FAIL_CNT=7, FIRST_FAIL=4'd3, PASS=0, ARC_MASK=8'h00.
- ZN stuck at 0, FAIL_CNT_W=2 → FAIL_CNT saturates at 3 (9 true failures), FIRST_FAIL=4'd0, PASS=0.
- ZN=X for vector 5 only, otherwise ideal → FAIL_CNT=1, FIRST_FAIL=4'd5.
- START pulsed again at vector 6, then RST asserted one cycle at vector 9 →
  - Second START ignored.
  - After the RST edge: all outputs at reset values, state IDLE.
  - A new START completes normally.
- Run completes, START pulsed from DONE → DONE/PASS cleared next edge and a full new run executes with identical timing.
